// File: rtl/dmem_lsu_mem.sv
// dmem_lsu_mem: word-organised data memory with byte/half/word load-store unit,
// optional zero-fill sweep after reset and 1- or 2-cycle load response latency.
`default_nettype none

module dmem_lsu_mem #(
  parameter int ADDR_WIDTH     = 14,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_e;

  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;

  logic [31:0]             mem_q [DEPTH];

  logic                    accept;
  logic                    misalign;
  logic                    wr_en;
  logic                    rd_accept;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [1:0]              offset;
  logic [3:0]              byte_en;
  logic [31:0]             wdata_sh;

  logic                    s1_valid_q;
  logic                    s1_err_q;
  logic [31:0]             s1_word_q;
  logic [1:0]              s1_size_q;
  logic                    s1_uns_q;
  logic [1:0]              s1_off_q;
  logic [31:0]             rd_shifted;
  logic [31:0]             ext_data;

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state_q)
      S_CLEAR: begin
        busy      = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d   = S_RUN;
          clr_cnt_d = '0;
        end
      end
      S_RUN: begin
        req_ready = 1'b1;
      end
      default: state_d = S_RUN;
    endcase
  end

  // --------------------------------------------------------- request decode
  assign accept   = req_valid & req_ready;
  assign word_idx = req_addr[ADDR_WIDTH+1:2];
  assign offset   = req_addr[1:0];

  always_comb begin
    misalign = 1'b0;
    byte_en  = 4'b0000;
    case (req_size)
      2'b00: byte_en  = 4'b0001 << offset;
      2'b01: begin
        misalign = offset[0];
        byte_en  = 4'b0011 << offset;
      end
      2'b10: begin
        misalign = (offset != 2'b00);
        byte_en  = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  assign wdata_sh  = req_wdata << {offset, 3'b000};
  assign wr_en     = accept & req_we & ~misalign;
  // Misaligned stores still return an error response, so they travel the load path.
  assign rd_accept = accept & (~req_we | misalign);

  // ----------------------------------------------------------------- memory
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------- read stage 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_word_q  <= '0;
      s1_size_q  <= 2'b00;
      s1_uns_q   <= 1'b0;
      s1_off_q   <= 2'b00;
    end else begin
      s1_valid_q <= rd_accept;
      if (rd_accept) begin
        s1_err_q  <= misalign;
        s1_word_q <= misalign ? 32'h0 : mem_q[word_idx];
        s1_size_q <= req_size;
        s1_uns_q  <= req_unsigned;
        s1_off_q  <= offset;
      end
    end
  end

  assign rd_shifted = s1_word_q >> {s1_off_q, 3'b000};

  always_comb begin
    ext_data = rd_shifted;
    case (s1_size_q)
      2'b00: ext_data = s1_uns_q ? {24'h0, rd_shifted[7:0]}
                                 : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01: ext_data = s1_uns_q ? {16'h0, rd_shifted[15:0]}
                                 : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: ext_data = rd_shifted;
    endcase
    if (s1_err_q) begin
      ext_data = 32'h0;
    end
  end

  // -------------------------------------------------------- response output
  // Stage-1 fields only change on a new read, so the outputs hold between responses.
  if (READ_LATENCY == 2) begin : g_lat2
    logic        s2_valid_q;
    logic        s2_err_q;
    logic [31:0] s2_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_rdata_q <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_err_q   <= s1_err_q;
          s2_rdata_q <= ext_data;
        end
      end
    end

    assign rsp_valid = s2_valid_q;
    assign rsp_err   = s2_valid_q & s2_err_q;
    assign rsp_rdata = s2_rdata_q;
  end else begin : g_lat1
    assign rsp_valid = s1_valid_q;
    assign rsp_err   = s1_valid_q & s1_err_q;
    assign rsp_rdata = ext_data;
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_lsu_mem.sv
// Directed bench for dmem_lsu_mem: a latency-1 and a latency-2 instance share
// one request stream; vectors carry hand-computed expected responses.
`default_nettype none

module tb_dmem_lsu_mem;

  localparam int AW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [AW+1:0] req_addr = '0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;

  logic        ready1, busy1, valid1, err1;
  logic [31:0] rdata1;
  logic        ready2, busy2, valid2, err2;
  logic [31:0] rdata2;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last1 = 32'h0;

  always #5 clk = ~clk;

  dmem_lsu_mem #(.ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready1),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(valid1),
    .rsp_rdata(rdata1), .rsp_err(err1), .busy(busy1)
  );

  dmem_lsu_mem #(.ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready2),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata), .rsp_valid(valid2),
    .rsp_rdata(rdata2), .rsp_err(err2), .busy(busy2)
  );

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic        ev;
    logic        ee;
    logic [31:0] ed;
  } vec_t;

  localparam int NV = 21;
  vec_t vt [NV];

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_we       = v.we;
    req_addr     = v.addr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_wdata    = v.wdata;
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk); #1;
    check("l1_valid", idx, 32'(valid1), 32'(v.ev));
    check("l1_err",   idx, 32'(err1),   32'(v.ee));
    if (v.ev) begin
      check("l1_rdata", idx, rdata1, v.ed);
      last1 = v.ed;
    end
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("l1_idle",  idx, 32'(valid1), 32'h0);
    check("l1_hold",  idx, rdata1, last1);
    check("l2_valid", idx, 32'(valid2), 32'(v.ev));
    check("l2_err",   idx, 32'(err2),   32'(v.ee));
    if (v.ev) check("l2_rdata", idx, rdata2, v.ed);
  endtask

  function automatic vec_t ld(input logic [5:0] a, input logic [1:0] s, input logic u,
                              input logic err, input logic [31:0] d);
    vec_t v;
    v = '{we: 1'b0, addr: a, size: s, uns: u, wdata: 32'h0, ev: 1'b1, ee: err, ed: d};
    return v;
  endfunction

  function automatic vec_t st(input logic [5:0] a, input logic [1:0] s, input logic [31:0] w,
                              input logic err);
    vec_t v;
    v = '{we: 1'b1, addr: a, size: s, uns: 1'b0, wdata: w, ev: err, ee: err, ed: 32'h0};
    return v;
  endfunction

  initial begin
    int n;
    int pulses;

    vt[0]  = ld(6'h3C, 2'b10, 1'b0, 1'b0, 32'h0000_0000);
    vt[1]  = st(6'h10, 2'b10, 32'h80F0_1234, 1'b0);
    vt[2]  = ld(6'h11, 2'b00, 1'b0, 1'b0, 32'h0000_0012);
    vt[3]  = ld(6'h13, 2'b00, 1'b1, 1'b0, 32'h0000_0080);
    vt[4]  = ld(6'h12, 2'b01, 1'b0, 1'b0, 32'hFFFF_80F0);
    vt[5]  = ld(6'h12, 2'b01, 1'b1, 1'b0, 32'h0000_80F0);
    vt[6]  = ld(6'h13, 2'b00, 1'b0, 1'b0, 32'hFFFF_FF80);
    vt[7]  = ld(6'h10, 2'b10, 1'b1, 1'b0, 32'h80F0_1234);
    vt[8]  = st(6'h20, 2'b10, 32'h1122_3344, 1'b0);
    vt[9]  = st(6'h22, 2'b00, 32'hFFFF_FFAB, 1'b0);
    vt[10] = ld(6'h20, 2'b10, 1'b0, 1'b0, 32'h11AB_3344);
    vt[11] = st(6'h04, 2'b10, 32'hCAFE_F00D, 1'b0);
    vt[12] = st(6'h06, 2'b10, 32'h1234_5678, 1'b1);
    vt[13] = ld(6'h03, 2'b01, 1'b0, 1'b1, 32'h0000_0000);
    vt[14] = ld(6'h04, 2'b10, 1'b0, 1'b0, 32'hCAFE_F00D);
    vt[15] = ld(6'h08, 2'b11, 1'b0, 1'b1, 32'h0000_0000);
    vt[16] = st(6'h0E, 2'b01, 32'h0000_BEEF, 1'b0);
    vt[17] = ld(6'h0C, 2'b10, 1'b0, 1'b0, 32'hBEEF_0000);
    vt[18] = ld(6'h0E, 2'b01, 1'b0, 1'b0, 32'hFFFF_BEEF);
    vt[19] = ld(6'h0F, 2'b00, 1'b1, 1'b0, 32'h0000_00BE);
    vt[20] = ld(6'h0D, 2'b01, 1'b1, 1'b1, 32'h0000_0000);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  0, 32'(busy1),  32'h1);
    check("rst_ready", 0, 32'(ready1), 32'h0);
    check("rst_valid", 0, 32'(valid1 | valid2), 32'h0);
    check("rst_err",   0, 32'(err1 | err2), 32'h0);
    check("rst_rdata", 0, rdata1 | rdata2, 32'h0);

    // Interrupt the sweep at index 7; it must restart from 0
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_busy", 0, 32'(busy1), 32'h1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    pulses = 0;
    while (busy1 && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (valid1 || valid2) pulses++;
    end
    check("clear_cycles", 0, 32'(n), 32'd16);
    check("clear_pulses", 0, 32'(pulses), 32'd0);
    check("run_ready1", 0, 32'(ready1), 32'h1);
    check("run_ready2", 0, 32'(ready2 & ~busy2), 32'h1);

    for (int i = 0; i < NV; i++) begin
      apply(i, vt[i]);
    end

    // Back-to-back loads: latency-2 responses follow one cycle behind
    @(negedge clk);
    drive(ld(6'h10, 2'b10, 1'b0, 1'b0, 32'h0));
    @(posedge clk); #1;
    check("b2b_l1_a", 0, rdata1, 32'h80F0_1234);
    check("b2b_l2_v0", 0, 32'(valid2), 32'h0);
    @(negedge clk);
    drive(ld(6'h20, 2'b10, 1'b0, 1'b0, 32'h0));
    @(posedge clk); #1;
    check("b2b_l1_b", 0, rdata1, 32'h11AB_3344);
    check("b2b_l2_v1", 0, 32'(valid2), 32'h1);
    check("b2b_l2_a", 0, rdata2, 32'h80F0_1234);
    @(negedge clk);
    drive(ld(6'h11, 2'b00, 1'b0, 1'b0, 32'h0));
    @(posedge clk); #1;
    check("b2b_l1_c", 0, rdata1, 32'h0000_0012);
    check("b2b_l2_v2", 0, 32'(valid2), 32'h1);
    check("b2b_l2_b", 0, rdata2, 32'h11AB_3344);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_l1_v", 0, 32'(valid1), 32'h0);
    check("b2b_l2_v3", 0, 32'(valid2), 32'h1);
    check("b2b_l2_c", 0, rdata2, 32'h0000_0012);
    @(posedge clk); #1;
    check("b2b_l2_v4", 0, 32'(valid2), 32'h0);
    check("b2b_l2_hold", 0, rdata2, 32'h0000_0012);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
